// File: rtl/count_display_driver.sv
// Converts an 8-bit count to three BCD digits with a sequential double-dabble engine
// and drives a 3-digit multiplexed common-anode 7-segment display with leading-zero blanking.
module count_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  DIN,
    output logic [11:0] BCD,
    output logic        BUSY,
    output logic [6:0]  SEG,
    output logic [2:0]  AN
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [19:0]      shreg_q, shreg_d;
    logic [2:0]       iter_q, iter_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;
    logic [19:0]      adj;

    function automatic logic [6:0] seg_dec(input logic [3:0] d);
        case (d)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h7F;
        endcase
    endfunction

    always_comb begin
        adj = shreg_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (shreg_q[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = shreg_q[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                shreg_d = {12'h000, DIN};
                iter_d  = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                shreg_d = adj << 1;
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                bcd_d   = shreg_q[19:8];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Digit select, blanking and segment lookup happen only on the refresh wrap,
    // so the display always shows the BCD value present at that edge.
    always_comb begin
        logic       wrap;
        logic [3:0] nib;
        logic       blank;
        wrap    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        digit_d = digit_q;
        seg_d   = seg_q;
        an_d    = an_q;
        nib     = bcd_q[3:0];
        blank   = 1'b0;
        if (wrap) begin
            digit_d = (digit_q >= 2'd2) ? 2'd0 : digit_q + 2'd1;
            case (digit_d)
                2'd1: begin
                    nib   = bcd_q[7:4];
                    blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                end
                2'd2: begin
                    nib   = bcd_q[11:8];
                    blank = (bcd_q[11:8] == 4'd0);
                end
                default: begin
                    nib   = bcd_q[3:0];
                    blank = 1'b0;
                end
            endcase
            an_d  = ~(3'b001 << digit_d);
            seg_d = blank ? 7'h7F : seg_dec(nib);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            digit_q <= 2'd2;
            seg_q   <= 7'h7F;
            an_q    <= 3'b111;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign BCD  = bcd_q;
    assign BUSY = (state_q != S_IDLE);
    assign SEG  = seg_q;
    assign AN   = an_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver: conversion latency/values, DIN isolation,
// display multiplexing with blanking, and reset abort mid-conversion.
module tb_count_display_driver;

    logic        CLK;
    logic        RST_N;
    logic [7:0]  DIN;
    logic [11:0] BCD;
    logic        BUSY;
    logic [6:0]  SEG;
    logic [2:0]  AN;

    int unsigned n_tests;
    int unsigned n_fail;

    count_display_driver #(.REFRESH_DIV(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .DIN   (DIN),
        .BCD   (BCD),
        .BUSY  (BUSY),
        .SEG   (SEG),
        .AN    (AN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int unsigned guard;
        guard = 0;
        while (BUSY && guard < 20) begin
            tick();
            guard++;
        end
        check_eq("wait_idle", {11'b0, BUSY}, 12'h000);
    endtask

    // Samples din on the next edge; result must appear exactly 9 edges later.
    task automatic run_conv(input string tag, input logic [7:0] din,
                            input logic [11:0] exp, input logic [11:0] prev);
        wait_idle();
        DIN = din;
        tick();
        check_eq({tag, "_busy"}, {11'b0, BUSY}, 12'h001);
        repeat (8) tick();
        check_eq({tag, "_early"}, BCD, prev);
        tick();
        check_eq(tag, BCD, exp);
        check_eq({tag, "_idle"}, {11'b0, BUSY}, 12'h000);
    endtask

    initial begin
        logic [2:0] an_tab [3];
        logic [6:0] seg7_tab [3];
        logic [6:0] seg105_tab [3];
        int unsigned idx;

        an_tab     = '{3'b110, 3'b101, 3'b011};
        seg7_tab   = '{7'h78, 7'h7F, 7'h7F};
        seg105_tab = '{7'h12, 7'h40, 7'h79};
        n_tests = 0;
        n_fail  = 0;
        RST_N   = 1'b0;
        DIN     = 8'd0;

        repeat (3) tick();
        check_eq("rst_bcd", BCD, 12'h000);
        check_eq("rst_busy", {11'b0, BUSY}, 12'h000);
        check_eq("rst_seg", {5'b0, SEG}, 12'h07F);
        check_eq("rst_an", {9'b0, AN}, 12'h007);

        RST_N = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check_eq("busy_after_release", {11'b0, BUSY}, 12'h001);
        end
        tick();
        check_eq("first_conv_busy", {11'b0, BUSY}, 12'h000);
        check_eq("first_conv_bcd", BCD, 12'h000);

        run_conv("conv255", 8'd255, 12'h255, 12'h000);
        run_conv("conv100", 8'd100, 12'h100, 12'h255);
        run_conv("conv99",  8'd99,  12'h099, 12'h100);
        run_conv("conv9",   8'd9,   12'h009, 12'h099);

        wait_idle();
        DIN = 8'd42;
        tick();
        repeat (2) tick();
        DIN = 8'd200;
        repeat (7) tick();
        check_eq("din_ignored", BCD, 12'h042);
        run_conv("conv200", 8'd200, 12'h200, 12'h042);

        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        DIN   = 8'd7;
        for (int e = 1; e <= 27; e++) begin
            tick();
            if (e == 3) check_eq("mux_pre_an", {9'b0, AN}, 12'h007);
            if (e == 4) begin
                check_eq("mux_first_an", {9'b0, AN}, 12'h006);
                check_eq("mux_first_seg", {5'b0, SEG}, 12'h040);
            end
            if (e >= 16) begin
                idx = ((e / 4) - 1) % 3;
                check_eq("mux7_an", {9'b0, AN}, {9'b0, an_tab[idx]});
                check_eq("mux7_seg", {5'b0, SEG}, {5'b0, seg7_tab[idx]});
            end
        end

        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        DIN   = 8'd105;
        for (int e = 1; e <= 24; e++) begin
            tick();
            if (e == 16 || e == 20 || e == 24) begin
                idx = ((e / 4) - 1) % 3;
                check_eq("mux105_an", {9'b0, AN}, {9'b0, an_tab[idx]});
                check_eq("mux105_seg", {5'b0, SEG}, {5'b0, seg105_tab[idx]});
            end
        end

        wait_idle();
        check_eq("pre_abort_bcd", BCD, 12'h105);
        DIN = 8'd255;
        tick();
        repeat (4) tick();
        RST_N = 1'b0;
        tick();
        check_eq("abort_bcd", BCD, 12'h000);
        check_eq("abort_busy", {11'b0, BUSY}, 12'h000);
        check_eq("abort_an", {9'b0, AN}, 12'h007);
        check_eq("abort_seg", {5'b0, SEG}, 12'h07F);
        RST_N = 1'b1;
        tick();
        repeat (8) tick();
        check_eq("abort_hold", BCD, 12'h000);
        tick();
        check_eq("abort_reconv", BCD, 12'h255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_display_driver.md
# count_display_driver

Downstream consumer of the 8-bit free-running counter: takes its 8-bit count, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine and drives a 3-digit multiplexed common-anode 7-segment display. Leading zeros are blanked. Sits between the counter output and the board's display pins. The latched BCD value is also exported for debug and verification.

## Interface
Parameters:
- REFRESH_DIV, 50000, CLK cycles each digit stays lit; legal range ≥ 2.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST_N  input  1  synchronous active-low reset
- DIN  input  8  unsigned value to display, normally the counter's COUT
- BCD  output  12  latched conversion result {hundreds, tens, ones}, 4 bits each
- BUSY  output  1  high while a conversion is in progress (CONV or LATCH)
- SEG  output  7  active-low segments, bit order {g,f,e,d,c,b,a}
- AN  output  3  active-low digit enables: AN[0]=ones, AN[1]=tens, AN[2]=hundreds

## Operation
- One clock. Reset is synchronous and active-low.
- Reset values: state=IDLE, BCD=12'h000, BUSY=0, SEG=7'h7F, AN=3'b111, refresh counter=0, digit index=2.
- Converter FSM, 20-bit shift register {h,t,o,bin[7:0]}, 3-bit iteration counter:
  - IDLE: load shreg={12'h000, DIN}, iter=0, go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift the whole register left by 1. iter++. Go to LATCH after the 8th shift (iter==7).
  - LATCH: BCD <= shreg[19:8], go to IDLE.
- Conversion runs continuously: one sample every 10 cycles. DIN is sampled only in IDLE; DIN changes during CONV/LATCH are ignored until the next IDLE.
- BUSY=1 in CONV and LATCH, 0 in IDLE.
- Display multiplexer:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap edge, digit index advances 0→1→2→0, and AN and SEG are registered for the new digit.
- Segment encoding (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Blanking, evaluated on BCD at the wrap edge; a blanked digit drives SEG=7'h7F with its AN still asserted:
  - hundreds blanked when h==0;
  - tens blanked when h==0 and t==0;
  - ones never blanked.
- BCD nibbles are always in the range 0..9 (max value 255). Any other nibble value is unreachable; the decoder outputs 7'h7F for it.

## Timing
- Conversion latency: DIN sampled on edge n (IDLE). Shifts on edges n+1..n+8. BCD and the new value visible after edge n+9. Next sample on edge n+10.
- After reset release, the first IDLE sample is on the first edge with RST_N=1.
- First display update on edge REFRESH_DIV after reset release: digit index 2→0, AN=3'b110. Thereafter every REFRESH_DIV edges.
- SEG/AN reflect the BCD value present at their own wrap edge. A BCD update mid-digit is not shown until the next wrap.
- Reset asserted mid-conversion: on that edge the conversion is aborted and all reset values above are reloaded. The partial result is never latched, and BCD returns to 0.
- Reset has priority over all other activity. AN never has more than one bit low.

## Test plan
- Reset: hold RST_N=0 for 3 cycles → BCD=000, BUSY=0, SEG=7F, AN=111. Release with DIN=8'd0 → BUSY high on edges 1..9 after release, BCD=12'h000 after edge 9.
- Conversion values, one conversion each: DIN=255 → BCD=12'h255; DIN=100 → 12'h100; DIN=99 → 12'h099; DIN=9 → 12'h009. Each result appears exactly 9 edges after its sampling edge.
- DIN change while BUSY: sample DIN=42, change to 200 on the 3rd CONV cycle → BCD=12'h042. The next conversion yields 12'h200.
- Multiplex/blanking with REFRESH_DIV=4 and DIN=7 steady:
  - AN sequence 110,101,011 repeating every 4 cycles.
  - SEG = 78 for ones; 7F for tens and hundreds.
- Multiplex with DIN=105, REFRESH_DIV=4 → ones SEG=12, tens SEG=40 (zero shown, not blanked), hundreds SEG=79.
- Reset mid-conversion: sample DIN=255, assert RST_N=0 on the 5th CONV cycle for 1 cycle → BCD stays 000. After release, BCD=255 appears 9 edges after the new sample.
